// File: rtl/ps2_key_event_queue_if.sv
// ---------------------------------------------------------------------------
// ps2_key_event_queue_if
// Consumer-side bundle of the PS/2 key event queue.
//   ev_valid     : head of the event FIFO is valid
//   ev_ready     : consumer takes the head this cycle
//   ev_data      : {release, mods[9:0], key}
//   count        : FIFO occupancy
//   overflow     : sticky "event dropped because FIFO was full"
//   clr_overflow : clears overflow
// master = the queue (producer), slave = the CPU-side consumer.
// ---------------------------------------------------------------------------
interface ps2_key_event_queue_if #(
  parameter int KEY_W      = 7,
  parameter int DEPTH_LOG2 = 4
);
  logic                  ev_valid;
  logic                  ev_ready;
  logic [10+KEY_W:0]     ev_data;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  clr_overflow;

  modport master (
    output ev_valid, ev_data, count, overflow,
    input  ev_ready, clr_overflow
  );

  modport slave (
    input  ev_valid, ev_data, count, overflow,
    output ev_ready, clr_overflow
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// ---------------------------------------------------------------------------
// ps2_key_event_queue
// Turns raw PS/2 scan-code bytes into key events (make/break, E0 extended,
// E1 Pause), keeps a pressed-key bitmap, stamps each event with a modifier
// snapshot and queues it in a first-word-fall-through FIFO.
// Ports:
//   CLOCK_50, reset : clock, synchronous active-high reset
//   rx_data/rx_valid: byte from the PS/2 receiver
//   map_scan/map_ext: address of the external scan->key lookup
//   map_key         : lookup result (same cycle, 0 = unmapped)
//   query/is_pressed: combinational bitmap read port
//   ev              : event consumer port (valid/ready, count, overflow)
// ---------------------------------------------------------------------------
module ps2_key_event_queue #(
  parameter int                   DEPTH_LOG2    = 4,
  parameter int                   KEY_W         = 7,
  parameter bit                   FILTER_REPEAT = 1'b1,
  parameter logic [10*KEY_W-1:0]  MOD_CODES     = {7'h29, 7'h2A, 7'h2B, 7'h2C, 7'h2D,
                                                   7'h2E, 7'h2F, 7'h30, 7'h28, 7'h17},
  parameter logic [KEY_W-1:0]     PAUSE_CODE    = 7'h10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        map_scan,
  output logic              map_ext,
  input  logic [KEY_W-1:0]  map_key,
  input  logic [KEY_W-1:0]  query,
  output logic              is_pressed,
  ps2_key_event_queue_if.master ev
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int EV_W  = 11 + KEY_W;
  localparam int NKEYS = 2**KEY_W;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t                r_state, w_state_next;
  logic [2:0]            r_skip, w_skip_next;
  logic                  w_key_ev, w_rel, w_pause_ev;

  logic [NKEYS-1:0]      r_bitmap, w_bitmap_next;
  logic                  w_key_hit, w_push;
  logic [9:0]            w_mods;
  logic [EV_W-1:0]       w_ev_word;

  logic [EV_W-1:0]       r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  w_empty, w_full, w_pop, w_wr, w_drop;

  // ---------------- parser ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_skip_next  = r_skip;
    w_key_ev     = 1'b0;
    w_rel        = 1'b0;
    w_pause_ev   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          case (rx_data)
            8'hE0: w_state_next = S_EXT;
            8'hF0: w_state_next = S_BRK;
            8'hE1: begin
              w_state_next = S_PAUSE;
              w_skip_next  = 3'd7;   // bytes still to swallow after E1
            end
            // keyboard ACK/BAT/echo/resend/error bytes carry no key
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
              w_state_next = S_IDLE;
            end
            default: w_key_ev = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            w_state_next = S_EXT_BRK;
          end else if (rx_data == 8'hE0) begin
            w_state_next = S_EXT;
          end else begin
            w_key_ev     = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          w_key_ev     = 1'b1;
          w_rel        = 1'b1;
          w_state_next = S_IDLE;
        end
        S_PAUSE: begin
          w_skip_next = r_skip - 3'd1;
          if (r_skip == 3'd1) begin
            w_pause_ev   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign map_scan = rx_data;
  assign map_ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);

  // ---------------- bitmap and event word ----------------
  assign w_key_hit = w_key_ev && (map_key != '0);

  always_comb begin
    w_bitmap_next = r_bitmap;
    if (w_key_hit) begin
      w_bitmap_next[map_key] = ~w_rel;
    end
  end

  // Modifiers are sampled after the current event is applied, so a shift
  // make reports its own bit as set and a shift break reports it clear.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_mods
      assign w_mods[gi] = w_bitmap_next[MOD_CODES[gi*KEY_W +: KEY_W]];
    end
  endgenerate

  // Repeat filtering looks at the bitmap before this event's update.
  assign w_push = w_pause_ev |
                  (w_key_hit & (w_rel | ~(FILTER_REPEAT & r_bitmap[map_key])));
  assign w_ev_word = {w_rel, w_mods, (w_pause_ev ? PAUSE_CODE : map_key)};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_bitmap <= '0;
    end else begin
      r_bitmap <= w_bitmap_next;
    end
  end

  assign is_pressed = r_bitmap[query];

  // ---------------- event FIFO ----------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = ~w_empty & ev.ev_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_ev_word;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ev.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ev.ev_valid = ~w_empty;
  assign ev.ev_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign ev.count    = r_count;
  assign ev.overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_queue
// Two instances share the byte stream: dut0 uses the defaults (depth 16,
// repeat filter on), dut1 uses depth 4 with the repeat filter off.
// Stimulus is generated as abstract key events; the reference model applies
// each event directly to a pressed-key array and per-instance event queues.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_queue;
  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] query;
  logic [7:0] map_scan0, map_scan1;
  logic       map_ext0, map_ext1;
  logic [6:0] map_key0, map_key1;
  logic       is_pressed0, is_pressed1;
  logic       rdy0, rdy1, clr;

  ps2_key_event_queue_if #(.KEY_W(7), .DEPTH_LOG2(4)) if0 ();
  ps2_key_event_queue_if #(.KEY_W(7), .DEPTH_LOG2(2)) if1 ();

  assign if0.ev_ready     = rdy0;
  assign if1.ev_ready     = rdy1;
  assign if0.clr_overflow = clr;
  assign if1.clr_overflow = clr;

  // External scan->key lookup table used by both instances and the model.
  function automatic logic [6:0] lut(input logic [7:0] s, input logic e);
    if (e) begin
      if (s == 8'h75) return 7'h64;
      return (s < 8'h40) ? 7'(s + 8'h40) : 7'h00;
    end
    case (s)
      8'h12:   return 7'h29;
      8'h1C:   return 7'h4E;
      8'h75:   return 7'h24;
      default: return s[7] ? 7'h00 : s[6:0];
    endcase
  endfunction

  assign map_key0 = lut(map_scan0, map_ext0);
  assign map_key1 = lut(map_scan1, map_ext1);

  ps2_key_event_queue dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .map_scan(map_scan0), .map_ext(map_ext0), .map_key(map_key0),
    .query(query), .is_pressed(is_pressed0), .ev(if0.master)
  );

  ps2_key_event_queue #(.DEPTH_LOG2(2), .FILTER_REPEAT(1'b0)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .map_scan(map_scan1), .map_ext(map_ext1), .map_key(map_key1),
    .query(query), .is_pressed(is_pressed1), .ev(if1.master)
  );

  // ---------------- reference model ----------------
  int errors = 0;
  int checks = 0;
  bit          pressed [128];
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];
  bit          movf [2];
  int          mod_codes [10] = '{'h29, 'h2A, 'h2B, 'h2C, 'h2D, 'h2E, 'h2F, 'h30, 'h28, 'h17};

  bit         pend;
  int         pend_kind;   // 0 make, 1 break, 2 pause
  bit         pend_ext;
  logic [7:0] pend_scan;
  bit         rand_mode;
  int         rpct;

  function automatic int qsize(input int d);
    return (d != 0) ? q1.size() : q0.size();
  endfunction

  function automatic logic [17:0] qhead(input int d);
    if (qsize(d) == 0) return 18'h0;
    return (d != 0) ? q1[0] : q0[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input int d, input logic v, input logic [17:0] data,
                            input logic [31:0] cnt, input logic o);
    check($sformatf("ev_valid%0d", d), 32'(v), 32'(qsize(d) != 0));
    check($sformatf("ev_data%0d", d), 32'(data), 32'(qhead(d)));
    check($sformatf("count%0d", d), cnt, 32'(qsize(d)));
    check($sformatf("overflow%0d", d), 32'(o), 32'(movf[d]));
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic tick();
    logic [17:0] w;
    logic [6:0]  key;
    logic [9:0]  m;
    bit          rel, was, pf, pnf, push, ready, dropped;
    int          depth;
    if (rand_mode) begin
      rdy0  = ($urandom_range(99) < rpct);
      rdy1  = ($urandom_range(99) < rpct);
      clr   = ($urandom_range(99) < 5);
      query = 7'($urandom);
    end
    #1;
    if (!reset) begin
      check("map_scan", 32'(map_scan0), 32'(rx_data));
      check("is_pressed0", 32'(is_pressed0), 32'(pressed[query]));
      check("is_pressed1", 32'(is_pressed1), 32'(pressed[query]));
      check_fifo(0, if0.ev_valid, if0.ev_data, 32'(if0.count), if0.overflow);
      check_fifo(1, if1.ev_valid, if1.ev_data, 32'(if1.count), if1.overflow);
    end
    if (reset) begin
      foreach (pressed[i]) pressed[i] = 1'b0;
      q0.delete();
      q1.delete();
      movf[0] = 1'b0;
      movf[1] = 1'b0;
      pend    = 1'b0;
    end else begin
      pf = 1'b0; pnf = 1'b0; rel = 1'b0; w = '0; key = '0;
      if (pend) begin
        if (pend_kind == 2) begin
          key = 7'h10; pf = 1'b1; pnf = 1'b1;
        end else begin
          key = lut(pend_scan, pend_ext);
          rel = (pend_kind == 1);
          if (key != 0) begin
            was          = pressed[key];
            pressed[key] = !rel;
            pnf          = 1'b1;
            pf           = rel || !was;
          end
        end
        for (int i = 0; i < 10; i++) m[9-i] = pressed[mod_codes[i]];
        w    = {rel, m, key};
        pend = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        ready = (d != 0) ? rdy1 : rdy0;
        depth = (d != 0) ? 4 : 16;
        push  = (d != 0) ? pnf : pf;
        if (ready && qsize(d) > 0) begin
          if (d != 0) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        dropped = push && (qsize(d) >= depth);
        if (push && !dropped) begin
          if (d != 0) q1.push_back(w); else q0.push_back(w);
        end
        if (dropped) movf[d] = 1'b1;
        else if (clr) movf[d] = 1'b0;
      end
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fin);
    rx_data  = b;
    rx_valid = 1'b1;
    pend     = fin;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (rand_mode) repeat ($urandom_range(1)) tick();
  endtask

  // kind: 0 make, 1 break, 2 pause, 3 ignored byte
  task automatic do_event(input int kind, input bit ext, input logic [7:0] scan);
    pend_kind = kind;
    pend_ext  = ext;
    pend_scan = scan;
    case (kind)
      0: begin
        if (ext) send_byte(8'hE0, 1'b0);
        send_byte(scan, 1'b1);
      end
      1: begin
        if (ext) send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(scan, 1'b1);
      end
      2: begin
        send_byte(8'hE1, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
      end
      default: send_byte(scan, 1'b0);
    endcase
  endtask

  task automatic drain();
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    repeat (20) tick();
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    check("drained0", 32'(if0.count), 32'd0);
  endtask

  logic [7:0] scans   [10] = '{8'h12, 8'h1C, 8'h29, 8'h2A, 8'h2B, 8'h30, 8'h17, 8'h75, 8'h33, 8'h85};
  logic [7:0] escans  [5]  = '{8'h75, 8'h11, 8'h14, 8'h1F, 8'h70};
  logic [7:0] ignored [6]  = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] pseq    [8]  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    int r;
    rand_mode = 1'b0; rpct = 30;
    rdy0 = 1'b0; rdy1 = 1'b0; clr = 1'b0; query = '0;
    rx_valid = 1'b0; rx_data = '0; pend = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_count", 32'(if0.count), 32'd0);
    check("rst_data", 32'(if0.ev_data), 32'd0);
    check("rst_ovf", 32'(if1.overflow), 32'd0);

    // Basic make / break
    do_event(0, 1'b0, 8'h1C);
    check("mk_head", 32'(if0.ev_data), 32'({1'b0, 10'h0, 7'h4E}));
    query = 7'h4E; #1;
    check("mk_pressed", 32'(is_pressed0), 32'd1);
    do_event(1, 1'b0, 8'h1C);
    query = 7'h4E; #1;
    check("brk_pressed", 32'(is_pressed0), 32'd0);
    check("mkbrk_count", 32'(if0.count), 32'd2);
    drain();

    // Shift modifier stamping
    do_event(0, 1'b0, 8'h12);
    do_event(0, 1'b0, 8'h1C);
    do_event(1, 1'b0, 8'h1C);
    do_event(1, 1'b0, 8'h12);
    check("mods_head", 32'(if0.ev_data), 32'({1'b0, 10'h200, 7'h29}));
    check("mods_count", 32'(if0.count), 32'd4);
    drain();

    // Typematic filter: 2 events on dut0, 6 on dut1 (depth 4 -> overflow)
    repeat (5) do_event(0, 1'b0, 8'h1C);
    do_event(1, 1'b0, 8'h1C);
    check("filt_count0", 32'(if0.count), 32'd2);
    check("filt_count1", 32'(if1.count), 32'd4);
    check("filt_ovf1", 32'(if1.overflow), 32'd1);
    drain();
    clr = 1'b1; tick(); clr = 1'b0;

    // Extended key
    do_event(0, 1'b1, 8'h75);
    query = 7'h64; #1;
    check("ext_pressed64", 32'(is_pressed0), 32'd1);
    query = 7'h24; #1;
    check("ext_pressed24", 32'(is_pressed0), 32'd0);
    pend_kind = 1; pend_ext = 1'b1; pend_scan = 8'h75;
    send_byte(8'hE0, 1'b0);
    check("map_ext_e0", 32'(map_ext0), 32'd1);
    send_byte(8'hF0, 1'b0);
    check("map_ext_f0", 32'(map_ext0), 32'd1);
    send_byte(8'h75, 1'b1);
    check("map_ext_idle", 32'(map_ext0), 32'd0);
    check("ext_count", 32'(if0.count), 32'd2);
    drain();

    // Pause sequence
    pend_kind = 2;
    for (int i = 0; i < 8; i++) send_byte(pseq[i], i == 7);
    check("pause_count", 32'(if0.count), 32'd1);
    check("pause_head", 32'(if0.ev_data), 32'({1'b0, 10'h0, 7'h10}));
    query = 7'h10; #1;
    check("pause_bitmap", 32'(is_pressed0), 32'd0);
    drain();

    // Reset in the middle of the Pause skip
    for (int i = 0; i < 3; i++) send_byte(pseq[i], 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    do_event(0, 1'b0, 8'h1C);
    check("rst_mid_count", 32'(if0.count), 32'd1);
    check("rst_mid_head", 32'(if0.ev_data), 32'({1'b0, 10'h0, 7'h4E}));
    do_event(1, 1'b0, 8'h1C);
    drain();

    // Overflow on the depth-4 instance
    for (int k = 0; k < 5; k++) do_event(0, 1'b0, 8'(8'h31 + k));
    check("ovf_count1", 32'(if1.count), 32'd4);
    check("ovf_flag1", 32'(if1.overflow), 32'd1);
    check("ovf_head1", 32'(if1.ev_data), 32'({1'b0, 10'h0, 7'h31}));
    rdy1 = 1'b1;
    do_event(0, 1'b0, 8'h36);
    rdy1 = 1'b0;
    check("popush_count1", 32'(if1.count), 32'd4);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ovf1", 32'(if1.overflow), 32'd0);
    drain();

    // Randomized traffic
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rpct = (n < 200) ? 30 : 80;
      r = $urandom_range(15);
      if (r <= 5)       do_event(0, 1'b0, scans[$urandom_range(9)]);
      else if (r <= 10) do_event(1, 1'b0, scans[$urandom_range(9)]);
      else if (r <= 12) do_event(0, 1'b1, escans[$urandom_range(4)]);
      else if (r == 13) do_event(1, 1'b1, escans[$urandom_range(4)]);
      else if (r == 14) do_event(2, 1'b0, 8'h00);
      else              do_event(3, 1'b0, ignored[$urandom_range(5)]);
    end
    rand_mode = 1'b0;
    clr = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
